// File: rtl/pipeline_elastic.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_elastic
//  Purpose  : Valid/ready elastic pipeline of p_stages register stages.
//             Backpressure from the consumer travels upstream, word order is
//             preserved, no word is dropped or duplicated, and bubbles
//             collapse so that empty stages fill while the output is stalled.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    p_width   data word width in bits
//    p_stages  number of register stages (must be >= 1)
//  Ports
//    i_clk     clock, rising edge
//    i_rst     reset, asynchronous, active-high
//    i_valid   upstream word valid
//    o_ready   pipeline accepts a word this cycle
//    i_data    upstream word
//    o_valid   output word valid (registered)
//    i_ready   downstream accepts a word this cycle
//    o_data    output word (registered, stable while stalled)
//    o_count   words currently held, stages plus skid
//  Build option
//    PIPELINE_ELASTIC_SKID_EN  when defined, o_ready is registered and an
//                              extra one-word skid register adds capacity.
//                              When undefined, o_ready is combinational from
//                              i_ready through the advance chain.
// ============================================================================
module pipeline_elastic #(
    parameter int p_width  = 32,
    parameter int p_stages = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [p_width-1:0]            i_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [p_width-1:0]            o_data,
    output logic [$clog2(p_stages+2)-1:0] o_count
);

    localparam int                 c_CNT_W     = $clog2(p_stages + 2);
    localparam logic [c_CNT_W-1:0] c_COUNT_ONE = c_CNT_W'(1);

    generate
        if (p_stages < 1) begin : g_bad_stages
            $error("pipeline_elastic: p_stages must be at least 1");
        end
    endgenerate

    // Stage storage; index p_stages-1 is the output stage.
    logic [p_stages-1:0]              valid_q;
    logic [p_stages-1:0]              valid_d;
    logic [p_stages-1:0][p_width-1:0] data_q;
    logic [p_stages-1:0][p_width-1:0] data_d;
    logic [c_CNT_W-1:0]               count_q;
    logic [c_CNT_W-1:0]               count_d;

    logic [p_stages-1:0]              w_adv;
    logic [p_stages-1:0]              w_prev_valid;
    logic [p_stages-1:0][p_width-1:0] w_prev_data;
    logic                             w_src_valid;
    logic [p_width-1:0]               w_src_data;
    logic                             w_in_xfer;
    logic                             w_out_xfer;

    // A stage may load when it is empty or when the stage ahead of it is
    // itself advancing. Built as a running carry from the output stage back
    // to stage 0 so the vector never reads itself.
    always_comb begin : p_adv
        logic carry;
        carry = i_ready;
        w_adv = '0;
        for (int k = p_stages - 1; k >= 0; k--) begin
            carry    = !valid_q[k] || carry;
            w_adv[k] = carry;
        end
    end

`ifdef PIPELINE_ELASTIC_SKID_EN
    logic               skid_valid_q;
    logic               skid_valid_d;
    logic [p_width-1:0] skid_data_q;
    logic [p_width-1:0] skid_data_d;

    // Ready depends only on skid state, which cuts the i_ready -> o_ready path.
    assign o_ready     = !skid_valid_q;
    assign w_in_xfer   = i_valid && o_ready;
    // A parked skid word is older than anything on i_data, so it goes first.
    assign w_src_valid = skid_valid_q || w_in_xfer;
    assign w_src_data  = skid_valid_q ? skid_data_q : i_data;

    always_comb begin : p_skid_next
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q && w_adv[0]) begin
            skid_valid_d = 1'b0;
        end else if (w_in_xfer && !w_adv[0]) begin
            skid_valid_d = 1'b1;
            skid_data_d  = i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin : p_skid_reg
        if (i_rst) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign o_ready     = w_adv[0];
    assign w_in_xfer   = i_valid && w_adv[0];
    assign w_src_valid = i_valid;
    assign w_src_data  = i_data;
`endif

    assign w_out_xfer = valid_q[p_stages-1] && i_ready;

    // Source feeding each stage: stage 0 takes the input side, the rest take
    // the stage behind them.
    generate
        for (genvar k = 0; k < p_stages; k++) begin : g_src
            if (k == 0) begin : g_head
                assign w_prev_valid[k] = w_src_valid;
                assign w_prev_data[k]  = w_src_data;
            end else begin : g_body
                assign w_prev_valid[k] = valid_q[k-1];
                assign w_prev_data[k]  = data_q[k-1];
            end
        end
    endgenerate

    // Loading from an empty source clears the valid bit but keeps the data,
    // so o_data does not wander while o_valid is low.
    always_comb begin : p_stage_next
        valid_d = valid_q;
        data_d  = data_q;
        for (int k = 0; k < p_stages; k++) begin
            if (w_adv[k]) begin
                valid_d[k] = w_prev_valid[k];
                if (w_prev_valid[k]) begin
                    data_d[k] = w_prev_data[k];
                end
            end
        end
    end

    always_comb begin : p_count_next
        count_d = count_q;
        if (w_in_xfer && !w_out_xfer) begin
            count_d = count_q + c_COUNT_ONE;
        end else if (!w_in_xfer && w_out_xfer) begin
            count_d = count_q - c_COUNT_ONE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin : p_stage_reg
        if (i_rst) begin
            valid_q <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign o_valid = valid_q[p_stages-1];
    assign o_data  = data_q[p_stages-1];
    assign o_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_elastic.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_elastic
//  Purpose  : Self-checking bench for pipeline_elastic. A queue-based model
//             predicts o_valid/o_data/o_ready/o_count every cycle; directed
//             scenarios add hand-computed expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_elastic;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam int CW = $clog2(N + 2);
`ifdef PIPELINE_ELASTIC_SKID_EN
    localparam int SKID = 1;
`else
    localparam int SKID = 0;
`endif
    localparam int CAP = N + SKID;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b0;
    logic [W-1:0]  i_data  = '0;
    logic          o_ready;
    logic          o_valid;
    logic [W-1:0]  o_data;
    logic [CW-1:0] o_count;

    pipeline_elastic #(.p_width(W), .p_stages(N)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_count (o_count)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: words held in stages are a queue in arrival order,
    // each tagged with the edge on which it entered stage 0. The oldest
    // word reaches the output p_stages-1 edges after entry (nothing ahead
    // of it can block it). Ready without skid is low only when every stage
    // holds a word and the consumer stalls.
    // ------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] d;
        int           e;
    } ent_t;

    ent_t         mq[$];
    int           t_edge   = 0;
    bit           m_skid_v = 1'b0;
    logic [W-1:0] m_skid_d = '0;
    logic [W-1:0] m_last   = '0;

    initial begin : p_model
        bit           ev;
        bit           er;
        bit           stall;
        bit           in_x;
        bit           out_x;
        logic [W-1:0] ed;
        logic [W-1:0] din;
        in_x  = 1'b0;
        out_x = 1'b0;
        stall = 1'b0;
        din   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mq.delete();
                m_skid_v = 1'b0;
                m_last   = '0;
                in_x     = 1'b0;
                out_x    = 1'b0;
                chk("rst_o_valid", o_valid, 0);
                chk("rst_o_count", o_count, 0);
                chk("rst_o_data",  o_data,  0);
            end else begin
                ev    = (mq.size() > 0) && (t_edge - mq[0].e >= N - 1);
                ed    = ev ? mq[0].d : m_last;
                if (ev) m_last = mq[0].d;
                stall = (mq.size() == N) && !i_ready;
                er    = (SKID != 0) ? !m_skid_v : !stall;
                chk("o_valid", o_valid, ev);
                chk("o_data",  o_data,  ed);
                chk("o_ready", o_ready, er);
                chk("o_count", o_count, mq.size() + int'(m_skid_v));
                in_x  = i_valid && er;
                out_x = ev && i_ready;
                din   = i_data;
            end
            @(posedge clk);
            if (!rst) begin
                t_edge++;
                if (out_x) void'(mq.pop_front());
                if (SKID != 0 && m_skid_v && !stall) begin
                    mq.push_back('{d: m_skid_d, e: t_edge});
                    m_skid_v = 1'b0;
                end
                if (in_x) begin
                    if (SKID != 0 && stall) begin
                        m_skid_v = 1'b1;
                        m_skid_d = din;
                    end else begin
                        mq.push_back('{d: din, e: t_edge});
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin : p_drive
        int           first;
        int           acc;
        int           nin;
        int           nout;
        int           lat;
        int           n;
        int           pv;
        int           pr;
        bit           acc6;
        logic         r0;
        logic         r1;
        logic [W-1:0] first_d;
        logic [W-1:0] lat_d;
        logic [W-1:0] ex;
        logic [CW-1:0] cnt20;
        logic [W-1:0] outs [16];

        cyc();
        cyc();
        rst = 1'b0;

        // 1: back-to-back stream, no stall
        i_ready = 1'b1;
        first   = -1;
        first_d = '0;
        cnt20   = '0;
        for (int i = 0; i < 44; i++) begin
            i_valid = (i < 32);
            i_data  = W'(i + 1);
            @(negedge clk);
            if (first < 0 && o_valid) begin
                first   = i;
                first_d = o_data;
            end
            if (i == 20) cnt20 = o_count;
            cyc();
        end
        chk("t1_latency",   first,   8);
        chk("t1_first",     first_d, 32'h1);
        chk("t1_count_mid", cnt20,   8);

        // 2: fill against a stalled consumer
        do_reset();
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            i_valid = 1'b1;
            i_data  = W'(acc + 1);
            @(negedge clk);
            if (o_ready) acc++;
            cyc();
        end
        @(negedge clk);
        chk("t2_accepts", acc,     CAP);
        chk("t2_count",   o_count, CAP);
        chk("t2_ready",   o_ready, 0);
        chk("t2_valid",   o_valid, 1);
        chk("t2_data",    o_data,  32'h1);
        cyc();

        // 3: from full, consumer toggles
        nin  = 0;
        nout = 0;
        for (int i = 0; i < 20; i++) begin
            i_ready = (i % 2 == 0);
            i_valid = 1'b1;
            i_data  = W'(32'h200 + nin);
            @(negedge clk);
            if (o_ready) nin++;
            if (o_valid && i_ready) nout++;
            cyc();
        end
        @(negedge clk);
        chk("t3_in",    nin,     10);
        chk("t3_out",   nout,    10);
        chk("t3_count", o_count, CAP);
        cyc();

        // 4: bubble collapse behind a stalled word
        do_reset();
        i_valid = 1'b1;
        i_data  = 32'hA5;
        cyc();
        i_valid = 1'b0;
        repeat (10) cyc();
        for (int j = 0; j < 5; j++) begin
            i_valid = 1'b1;
            i_data  = W'(32'hB0 + j);
            cyc();
        end
        i_valid = 1'b0;
        repeat (8) cyc();
        @(negedge clk);
        chk("t4_count", o_count, 6);
        cyc();
        i_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            ex = (j == 0) ? 32'hA5 : W'(32'hB0 + j - 1);
            @(negedge clk);
            chk("t4_valid", o_valid, 1);
            chk("t4_data",  o_data,  ex);
            cyc();
        end
        @(negedge clk);
        chk("t4_empty", o_valid, 0);
        cyc();

        // 5: asynchronous reset mid-stream, then fresh latency
        do_reset();
        for (int j = 0; j < 5; j++) begin
            i_valid = 1'b1;
            i_data  = W'(32'h301 + j);
            cyc();
        end
        i_valid = 1'b0;
        repeat (10) cyc();
        @(negedge clk);
        chk("t5_count_pre", o_count, 5);
        chk("t5_data_pre",  o_data,  32'h301);
        cyc();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_valid", o_valid, 0);
        chk("t5_async_count", o_count, 0);
        chk("t5_async_data",  o_data,  0);
        cyc();
        rst     = 1'b0;
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'h77;
        lat     = -1;
        lat_d   = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (lat < 0 && o_valid) begin
                lat   = i;
                lat_d = o_data;
            end
            cyc();
            i_valid = 1'b0;
        end
        chk("t5_latency", lat,   8);
        chk("t5_data",    lat_d, 32'h77);

        // 6: ready path within a cycle, and 0xBEEF behind a full pipe
        do_reset();
        for (int j = 0; j < N; j++) begin
            i_valid = 1'b1;
            i_data  = W'(32'h400 + j);
            cyc();
        end
        i_valid = 1'b1;
        i_data  = 32'hBEEF;
        #1;
        r0      = o_ready;
        i_ready = 1'b1;
        #1;
        r1      = o_ready;
        i_ready = 1'b0;
        chk("t6_ready_lo", r0, SKID);
        chk("t6_ready_hi", r1, 1);
        @(negedge clk);
        acc6 = o_ready;
        cyc();
        if (acc6) i_valid = 1'b0;
        @(negedge clk);
        chk("t6_ready_full", o_ready, 0);
        chk("t6_count_full", o_count, CAP);
        cyc();
        i_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_ready && i_valid) acc6 = 1'b1;
            if (o_valid) begin
                if (n < 16) outs[n] = o_data;
                n++;
            end
            cyc();
            if (acc6) i_valid = 1'b0;
        end
        chk("t6_n_out", n,       N + 1);
        chk("t6_head",  outs[0], 32'h400);
        chk("t6_beef",  outs[N], 32'hBEEF);

        // Random traffic, with one reset in the middle
        do_reset();
        pv = 50;
        pr = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                pv = $urandom_range(10, 100);
                pr = $urandom_range(10, 100);
            end
            if (i == 1500) do_reset();
            i_valid = ($urandom_range(0, 99) < pv);
            i_ready = ($urandom_range(0, 99) < pr);
            i_data  = $urandom;
            cyc();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (20) cyc();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
